bcd_countdown_timer: RTL and testbench

//   Four-digit BCD mm:ss down-counter with load/start/stop control and a one-cycle done pulse.

---
 rtl/bcd_countdown_timer_if.sv | 24 ++
 rtl/bcd_countdown_timer.sv | 153 +++++++++++++++
 tb/tb_bcd_countdown_timer.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bcd_countdown_timer_if.sv
// bcd_countdown_timer_if: control and display signals of the BCD countdown timer.
// The master side drives load/start/stop/tick. The slave side (the timer) returns
// the digits, the state, and the zero/done flags.
interface bcd_countdown_timer_if;
  logic        load;
  logic [15:0] load_val;
  logic        start;
  logic        stop;
  logic        tick;
  logic [15:0] digits;
  logic [1:0]  state;
  logic        zero;
  logic        done;

  modport master (
    output load, load_val, start, stop, tick,
    input  digits, state, zero, done
  );

  modport slave (
    input  load, load_val, start, stop, tick,
    output digits, state, zero, done
  );
endinterface

// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer: four-digit BCD mm:ss down-counter.
// - load/start/stop control, with a tick prescaler.
// - A registered one-cycle done pulse fires when the count reaches 00:00.
// Optional macro AUTO_RELOAD_EN: the timer stays in RUN after reaching 00:00.
// The next qualifying decrement then reloads the preset, making a repeat timer.
module bcd_countdown_timer #(
  parameter int MIN_TENS_MAX = 5,
  parameter int PRESCALE     = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  bcd_countdown_timer_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam logic [3:0] MT_MAX  = 4'(MIN_TENS_MAX);
  localparam logic [7:0] PS_LAST = 8'(PRESCALE - 1);

  state_e      state_q, state_d;
  logic [15:0] digits_q, digits_d;
  logic [15:0] preset_q, preset_d;
  logic [7:0]  pcnt_q, pcnt_d;
  logic        done_q, done_d;
  logic [15:0] clamped;
  logic [15:0] decremented;

  // Out-of-range load digits are pulled down to the largest legal value of that digit.
  function automatic logic [15:0] clamp_digits(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    mt = (v[15:12] > MT_MAX) ? MT_MAX : v[15:12];
    mo = (v[11:8]  > 4'd9)   ? 4'd9   : v[11:8];
    st = (v[7:4]   > 4'd5)   ? 4'd5   : v[7:4];
    so = (v[3:0]   > 4'd9)   ? 4'd9   : v[3:0];
    return {mt, mo, st, so};
  endfunction

  // Decrement by one second.
  // Each digit borrows from the next one up when it is zero.
  function automatic logic [15:0] bcd_dec(input logic [15:0] v);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = v;
    if (so != 4'd0) begin
      so = so - 4'd1;
    end else begin
      so = 4'd9;
      if (st != 4'd0) begin
        st = st - 4'd1;
      end else begin
        st = 4'd5;
        if (mo != 4'd0) begin
          mo = mo - 4'd1;
        end else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign clamped     = clamp_digits(bus.load_val);
  assign decremented = bcd_dec(digits_q);

  // Next-state logic.
  // - Priority is load > stop > start > tick.
  // - The prescaler only advances while running, and is held while paused.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    preset_d = preset_q;
    pcnt_d   = pcnt_q;
    done_d   = 1'b0;
    if (bus.load) begin
      digits_d = clamped;
      preset_d = clamped;
      state_d  = IDLE;
      pcnt_d   = 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!bus.stop && bus.start && digits_q != 16'h0000) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (bus.stop) begin
            state_d = PAUSE;
          end else if (bus.tick) begin
            if (pcnt_q == PS_LAST) begin
              pcnt_d = 8'd0;
`ifdef AUTO_RELOAD_EN
              if (digits_q == 16'h0000) begin
                digits_d = preset_q;
              end else begin
                digits_d = decremented;
                done_d   = (decremented == 16'h0000);
              end
`else
              digits_d = decremented;
              if (decremented == 16'h0000) begin
                done_d  = 1'b1;
                state_d = DONE;
              end
`endif
            end else begin
              pcnt_d = pcnt_q + 8'd1;
            end
          end
        end
        PAUSE: begin
          if (!bus.stop && bus.start) begin
            state_d = RUN;
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, digit, preset, prescaler and done-pulse registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      digits_q <= 16'h0000;
      preset_q <= 16'h0000;
      pcnt_q   <= 8'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      preset_q <= preset_d;
      pcnt_q   <= pcnt_d;
      done_q   <= done_d;
    end
  end

  assign bus.digits = digits_q;
  assign bus.state  = state_q;
  assign bus.zero   = (digits_q == 16'h0000);
  assign bus.done   = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer: randomized and directed checks of the BCD countdown timer.
// The reference model tracks the count as a plain number of seconds, and converts it to mm:ss BCD only for comparison.
// Optional macro AUTO_RELOAD_EN selects the repeat-timer expectations.
module tb_bcd_countdown_timer;

  logic clk;
  logic reset_n;
  int   vectors;
  int   miscompares;

`ifdef AUTO_RELOAD_EN
  localparam logic [1:0] EXP_END = 2'b01;
`else
  localparam logic [1:0] EXP_END = 2'b11;
`endif

  bcd_countdown_timer_if bus ();
  bcd_countdown_timer_if bus_ps ();

  bcd_countdown_timer #(.MIN_TENS_MAX(5), .PRESCALE(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave));

  bcd_countdown_timer #(.MIN_TENS_MAX(5), .PRESCALE(3)) dut_ps (
    .clk(clk), .reset_n(reset_n), .bus(bus_ps.slave));

  // Free-running clock
  always #5 clk = ~clk;

  // Reference model state: seconds remaining, preset seconds, state code, prescale count
  int         m_secs;
  int         m_preset;
  int         m_pcnt;
  logic [1:0] m_state;
  logic       m_done;

  function automatic logic [15:0] secs_to_bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic int clamped_secs(input logic [15:0] v);
    int mt, mo, st, so;
    mt = (int'(v[15:12]) > 5) ? 5 : int'(v[15:12]);
    mo = (int'(v[11:8])  > 9) ? 9 : int'(v[11:8]);
    st = (int'(v[7:4])   > 5) ? 5 : int'(v[7:4]);
    so = (int'(v[3:0])   > 9) ? 9 : int'(v[3:0]);
    return mt * 600 + mo * 60 + st * 10 + so;
  endfunction

  task automatic model_reset();
    m_secs = 0; m_preset = 0; m_pcnt = 0; m_state = 2'b00; m_done = 1'b0;
  endtask

  // One clock of the timer rules for the PRESCALE=1 instance
  task automatic model_update(input logic l, input logic [15:0] lv,
                              input logic st, input logic sp, input logic tk);
    m_done = 1'b0;
    if (l) begin
      m_secs = clamped_secs(lv); m_preset = m_secs; m_state = 2'b00; m_pcnt = 0;
    end else if (m_state == 2'b11) begin
      m_state = 2'b11;
    end else if (sp) begin
      if (m_state == 2'b01) m_state = 2'b10;
    end else if (st && m_state != 2'b01) begin
      if (m_state == 2'b10 || m_secs > 0) m_state = 2'b01;
    end else if (tk && m_state == 2'b01) begin
      if (m_pcnt == 0) begin
        if (m_secs == 0) begin
          m_secs = m_preset;
        end else begin
          m_secs = m_secs - 1;
          if (m_secs == 0) begin
            m_done = 1'b1;
`ifndef AUTO_RELOAD_EN
            m_state = 2'b11;
`endif
          end
        end
      end else begin
        m_pcnt = m_pcnt + 1;
      end
    end
  endtask

  task automatic drive_main(input logic l, input logic [15:0] lv,
                            input logic st, input logic sp, input logic tk);
    bus.load = l; bus.load_val = lv; bus.start = st; bus.stop = sp; bus.tick = tk;
    @(posedge clk);
    model_update(l, lv, st, sp, tk);
    #1;
  endtask

  task automatic drive_ps(input logic l, input logic [15:0] lv,
                          input logic st, input logic sp, input logic tk);
    bus_ps.load = l; bus_ps.load_val = lv; bus_ps.start = st; bus_ps.stop = sp; bus_ps.tick = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (bus.digits !== 16'h0000 || bus.state !== 2'b00 || bus.done !== 1'b0 || bus.zero !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL reset_state: got digits=%h state=%b done=%b zero=%b expected 0000/00/0/1",
               bus.digits, bus.state, bus.done, bus.zero);
    end
    reset_n = 1'b1;
    model_reset();
    drive_main(1'b1, 16'h0030, 1'b0, 1'b0, 1'b0);
    drive_main(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    repeat (3) drive_main(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (bus.digits !== 16'h0027) begin
      miscompares++;
      $display("[TB] FAIL reset_pre_run: got %h expected 0027", bus.digits);
    end
    #2 reset_n = 1'b0;
    #1;
    vectors++;
    if (bus.digits !== 16'h0000 || bus.state !== 2'b00 || bus.done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_async: got digits=%h state=%b done=%b expected 0000/00/0",
               bus.digits, bus.state, bus.done);
    end
    model_reset();
    #3 reset_n = 1'b1;
  endtask

  task automatic test_countdown();
    drive_main(1'b1, 16'h0102, 1'b0, 1'b0, 1'b0);
    drive_main(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 62; i++) begin
      drive_main(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (bus.digits !== secs_to_bcd(m_secs)) begin
        miscompares++;
        $display("[TB] FAIL countdown_tick%0d: got %h expected %h", i, bus.digits, secs_to_bcd(m_secs));
      end
      if (i == 1 || i == 3 || i == 62) begin
        vectors++;
        if (bus.digits !== ((i == 1) ? 16'h0101 : (i == 3) ? 16'h0059 : 16'h0000)) begin
          miscompares++;
          $display("[TB] FAIL countdown_point%0d: got %h", i, bus.digits);
        end
      end
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.state !== EXP_END || bus.zero !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL countdown_end: got done=%b state=%b zero=%b expected 1/%b/1",
               bus.done, bus.state, bus.zero, EXP_END);
    end
    drive_main(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus.done !== 1'b0 || bus.state !== EXP_END || bus.digits !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL countdown_after: got done=%b state=%b digits=%h expected 0/%b/0000",
               bus.done, bus.state, bus.digits, EXP_END);
    end
  endtask

  task automatic test_stop_priority();
    drive_main(1'b1, 16'h0005, 1'b0, 1'b0, 1'b0);
    drive_main(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    drive_main(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    drive_main(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    vectors++;
    if (bus.digits !== 16'h0004 || bus.state !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL stop_tick: got %h/%b expected 0004/10", bus.digits, bus.state);
    end
    drive_main(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    vectors++;
    if (bus.state !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL stop_beats_start: got %b expected 10", bus.state);
    end
    drive_main(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    drive_main(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (bus.digits !== 16'h0003 || bus.state !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL resume: got %h/%b expected 0003/01", bus.digits, bus.state);
    end
  endtask

  task automatic test_clamp();
    drive_main(1'b1, 16'hFA7C, 1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus.digits !== 16'h5959 || bus.state !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL clamp: got %h/%b expected 5959/00", bus.digits, bus.state);
    end
    drive_main(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    drive_main(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    vectors++;
    if (bus.state !== 2'b00 || bus.zero !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL start_at_zero: got state=%b zero=%b expected 00/1", bus.state, bus.zero);
    end
  endtask

  task automatic test_prescale();
    drive_ps(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    drive_ps(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      drive_ps(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (bus_ps.digits !== ((i < 3) ? 16'h0002 : (i < 6) ? 16'h0001 : 16'h0000)) begin
        miscompares++;
        $display("[TB] FAIL prescale_tick%0d: got %h", i, bus_ps.digits);
      end
    end
    vectors++;
    if (bus_ps.done !== 1'b1 || bus_ps.state !== EXP_END) begin
      miscompares++;
      $display("[TB] FAIL prescale_done: got done=%b state=%b expected 1/%b", bus_ps.done, bus_ps.state, EXP_END);
    end
    drive_ps(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    drive_ps(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    drive_ps(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    drive_ps(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    drive_ps(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    drive_ps(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    drive_ps(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    vectors++;
    if (bus_ps.digits !== 16'h0001 || bus_ps.state !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL prescale_pause_hold: got %h/%b expected 0001/01", bus_ps.digits, bus_ps.state);
    end
    drive_ps(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

`ifdef AUTO_RELOAD_EN
  task automatic test_end_behaviour();
    drive_main(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    drive_main(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      drive_main(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (bus.digits !== ((i == 1) ? 16'h0001 : (i == 2) ? 16'h0000 : 16'h0002) ||
          bus.state !== 2'b01 || bus.done !== (i == 2)) begin
        miscompares++;
        $display("[TB] FAIL reload_tick%0d: got %h/%b done=%b", i, bus.digits, bus.state, bus.done);
      end
    end
  endtask
`else
  task automatic test_end_behaviour();
    drive_main(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    drive_main(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    drive_main(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);
    drive_main(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    vectors++;
    if (bus.digits !== 16'h0000 || bus.state !== 2'b11 || bus.done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL done_hold: got %h/%b done=%b expected 0000/11/0", bus.digits, bus.state, bus.done);
    end
  endtask
`endif

  task automatic test_random();
    logic l, st, sp, tk;
    logic [15:0] lv;
    for (int n = 0; n < 600; n++) begin
      l  = ($urandom_range(99) < 4);
      lv = ($urandom_range(1) == 1) ? 16'($urandom) : secs_to_bcd(int'($urandom_range(15)));
      st = ($urandom_range(99) < 20);
      sp = ($urandom_range(99) < 8);
      tk = ($urandom_range(99) < 50);
      drive_main(l, lv, st, sp, tk);
      vectors++;
      if (bus.digits !== secs_to_bcd(m_secs) || bus.state !== m_state ||
          bus.done !== m_done || bus.zero !== (m_secs == 0)) begin
        miscompares++;
        $display("[TB] FAIL random_%0d: got %h/%b done=%b zero=%b expected %h/%b done=%b",
                 n, bus.digits, bus.state, bus.done, bus.zero, secs_to_bcd(m_secs), m_state, m_done);
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    reset_n = 1'b0;
    vectors = 0;
    miscompares = 0;
    bus.load = 1'b0; bus.load_val = 16'h0000; bus.start = 1'b0; bus.stop = 1'b0; bus.tick = 1'b0;
    bus_ps.load = 1'b0; bus_ps.load_val = 16'h0000; bus_ps.start = 1'b0; bus_ps.stop = 1'b0; bus_ps.tick = 1'b0;
    model_reset();
    test_reset();
    test_countdown();
    test_stop_priority();
    test_clamp();
    test_prescale();
    test_end_behaviour();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
